// File: rtl/axis_pkg.sv
// Shared AXI4-Stream definitions for the axis_m / axis_s link.
//   AXIS_DATA_WIDTH : default tdata width
//   AXIS_CNT_WIDTH  : default width of the packet/beat status counters
//   axis_beat_t     : buffered beat format {last, data}; the MSB is tlast
package axis_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_CNT_WIDTH  = 16;

  typedef struct packed {
    logic                       last;
    logic [AXIS_DATA_WIDTH-1:0] data;
  } axis_beat_t;

endpackage

// File: rtl/axis_s_fifo.sv
// Synchronous first-word-fall-through FIFO used as the axis_s receive buffer.
// Ports:
//   aclk, areset_n : clock, asynchronous active-high reset
//   push / din     : write din at the tail (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   dout           : head entry, valid whenever empty=0
//   full, empty    : occupancy flags
//   level          : number of occupied entries, 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
module axis_s_fifo
  import axis_pkg::*;
#(
  parameter int WIDTH = AXIS_DATA_WIDTH + 1,
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge aclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge aclk or posedge areset_n) begin
    if (areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axis_s.sv
// AXI4-Stream slave: accepts beats from an axis_m master, buffers {tlast, tdata}
// in a FWFT FIFO and presents them to a local consumer via out_valid/rd.
// Ports:
//   aclk, areset_n           : clock, asynchronous active-high reset
//   tvalid, tready, tdata,
//   tlast                    : AXI4-Stream slave side
//   rd                       : consumer pop strobe (ignored while out_valid=0)
//   out_valid, out_data,
//   out_last                 : FIFO head; data/last read 0 while empty
//   level                    : FIFO occupancy
//   pkt_done                 : one-cycle pulse after a tlast beat is accepted
//   pkt_count                : completed packets (wraps)
//   beat_count               : beats accepted in the current packet (saturates)
module axis_s
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = AXIS_CNT_WIDTH
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic                   tvalid,
  output logic                   tready,
  input  logic [DATA_WIDTH-1:0]  tdata,
  input  logic                   tlast,
  input  logic                   rd,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   pkt_done,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   beat_count
);

  logic                  rdy_en;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH:0]   head;

  // rdy_en holds tready low through reset and releases it on the first edge
  // afterwards, keeping tready a function of registered state only.
  always_ff @(posedge aclk or posedge areset_n) begin
    if (areset_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  assign tready    = rdy_en & ~full;
  assign push      = tvalid & tready;
  assign pop       = rd & ~empty;
  assign out_valid = ~empty;
  assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid & head[DATA_WIDTH];

  // Entry layout {last, data} matches axis_beat_t.
  axis_s_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk     (aclk),
    .areset_n (areset_n),
    .push     (push),
    .pop      (pop),
    .din      ({tlast, tdata}),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  always_ff @(posedge aclk or posedge areset_n) begin
    if (areset_n) begin
      pkt_done   <= 1'b0;
      pkt_count  <= '0;
      beat_count <= '0;
    end else begin
      pkt_done <= push & tlast;
      if (push) begin
        if (tlast) begin
          pkt_count  <= pkt_count + 1'b1;
          beat_count <= '0;
        end else if (beat_count != '1) begin
          beat_count <= beat_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_s.sv
module tb_axis_s;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          rd;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [2:0]    level;
  logic          pkt_done;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] beat_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW:0] exp_q[$];

  axis_s #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .tvalid     (tvalid),
    .tready     (tready),
    .tdata      (tdata),
    .tlast      (tlast),
    .rd         (rd),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .level      (level),
    .pkt_done   (pkt_done),
    .pkt_count  (pkt_count),
    .beat_count (beat_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
    tvalid = v;
    tdata  = d;
    tlast  = l;
    if (v) exp_q.push_back({l, d});
  endtask

  // Monitor: a pop happens on the next rising edge; compare the head now.
  always @(negedge aclk) begin
    if (!areset_n && rd && out_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL pop_unexpected: got %0h expected nothing", {out_last, out_data});
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          tests_failed++;
          $display("FAIL pop_data: got %0h expected %0h", {out_last, out_data}, e);
        end
      end
    end
  end

  initial begin
    areset_n = 1'b1;
    tvalid = 1'b0; tdata = '0; tlast = 1'b0; rd = 1'b0;
    repeat (3) cyc();
    check("rst_tready", tready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_level", level, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_beat_count", beat_count, 0);
    areset_n = 1'b0;
    cyc();
    check("post_rst_tready", tready, 1);

    // Single-beat packet
    drive(1, 32'haaaa_bbbb, 1);
    cyc();
    drive(0, '0, 0);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 32'haaaa_bbbb);
    check("t1_out_last", out_last, 1);
    check("t1_level", level, 1);
    check("t1_pkt_done", pkt_done, 1);
    check("t1_pkt_count", pkt_count, 1);
    check("t1_beat_count", beat_count, 0);
    cyc();
    check("t1_pkt_done_low", pkt_done, 0);
    rd = 1; cyc(); rd = 0;
    check("t1_level_after_pop", level, 0);
    check("t1_empty", out_valid, 0);

    // Back-to-back beats
    drive(1, 32'hcccc_dddd, 0);
    cyc();
    check("t2_beat_count1", beat_count, 1);
    check("t2_pkt_done0", pkt_done, 0);
    drive(1, 32'h1234_5678, 1);
    cyc();
    drive(0, '0, 0);
    check("t2_beat_count0", beat_count, 0);
    check("t2_pkt_count", pkt_count, 2);
    check("t2_pkt_done", pkt_done, 1);
    check("t2_level2", level, 2);
    rd = 1;
    cyc();
    check("t2_level1", level, 1);
    cyc();
    rd = 0;
    check("t2_level0", level, 0);

    // Full / backpressure
    for (int i = 1; i <= 4; i++) begin
      drive(1, DW'(i), 0);
      cyc();
    end
    tvalid = 1; tdata = 32'd5; tlast = 1;
    check("t3_full_level", level, 4);
    check("t3_full_tready", tready, 0);
    cyc();
    check("t3_hold_level", level, 4);
    check("t3_hold_tready", tready, 0);
    check("t3_hold_beat_count", beat_count, 4);
    rd = 1; cyc(); rd = 0;
    check("t3_after_pop_level", level, 3);
    check("t3_after_pop_tready", tready, 1);
    exp_q.push_back({1'b1, 32'd5});
    cyc();
    drive(0, '0, 0);
    check("t3_level_refill", level, 4);
    check("t3_pkt_count", pkt_count, 3);
    check("t3_beat_count", beat_count, 0);
    rd = 1; repeat (4) cyc(); rd = 0;
    check("t3_drained", level, 0);

    // Simultaneous push and pop at level 2
    drive(1, 32'ha000_0000, 0); cyc();
    drive(1, 32'ha000_0001, 0); cyc();
    check("t4_level_start", level, 2);
    rd = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hb000_0000 + DW'(i), (i == 2));
      cyc();
      check("t4_level_hold", level, 2);
    end
    drive(0, '0, 0);
    check("t4_pkt_count", pkt_count, 4);
    check("t4_beat_count", beat_count, 0);
    repeat (2) cyc();
    rd = 0;
    check("t4_drained", level, 0);

    // Pop while empty, then push with rd still high
    rd = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t5_empty_level", level, 0);
      check("t5_empty_valid", out_valid, 0);
    end
    drive(1, 32'hc0de_0005, 1);
    cyc();
    drive(0, '0, 0);
    rd = 0;
    check("t5_level", level, 1);
    check("t5_out_valid", out_valid, 1);
    check("t5_out_data", out_data, 32'hc0de_0005);
    rd = 1; cyc(); rd = 0;
    check("t5_pkt_count", pkt_count, 5);
    check("t5_drained", level, 0);

    // Reset mid-packet, asserted between clock edges
    drive(1, 32'hd000_0000, 0); cyc();
    drive(1, 32'hd000_0001, 0); cyc();
    drive(0, '0, 0);
    check("t6_pre_beat_count", beat_count, 2);
    check("t6_pre_level", level, 2);
    #2;
    areset_n = 1'b1;
    exp_q.delete();
    #1;
    check("t6_rst_tready", tready, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_beat_count", beat_count, 0);
    check("t6_rst_pkt_count", pkt_count, 0);
    repeat (2) cyc();
    check("t6_hold_tready", tready, 0);
    #3;
    areset_n = 1'b0;
    cyc();
    check("t6_release_tready", tready, 1);
    drive(1, 32'he000_000e, 1);
    cyc();
    drive(0, '0, 0);
    check("t6_pkt_count", pkt_count, 1);
    check("t6_level", level, 1);
    rd = 1; cyc(); rd = 0;
    cyc();

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_s.md
Name: axis_s

Overview:
- AXI4-Stream slave (receiver) at the far end of an axis_m link.
- Accepts beats on tvalid/tready/tdata/tlast and buffers them, with tlast, in a small first-word-fall-through FIFO.
- Presents the buffered beats to a local consumer through a valid/rd pop interface.
- Maintains packet and beat counters for status and verification.

Parameters:
- DATA_WIDTH, 32, width of tdata and out_data.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 16, width of pkt_count and beat_count.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset_n  in  1  reset; asynchronous, active-high.
- tvalid  in  1  stream beat valid from the master.
- tready  out  1  slave ready.
- tdata  in  DATA_WIDTH  stream data.
- tlast  in  1  last beat of packet.
- rd  in  1  consumer pop strobe.
- out_valid  out  1  FIFO head is valid (FIFO not empty).
- out_data  out  DATA_WIDTH  FIFO head data.
- out_last  out  1  FIFO head tlast flag.
- level  out  clog2(DEPTH)+1  number of occupied entries.
- pkt_done  out  1  one-cycle pulse when a tlast beat is accepted.
- pkt_count  out  CNT_WIDTH  count of completed packets.
- beat_count  out  CNT_WIDTH  beats accepted so far in the current packet.

Behaviour:
- Reset (areset_n=1):
  - Asynchronously clears wr_ptr, rd_ptr, level, pkt_count and beat_count.
  - Drives tready=0, out_valid=0, pkt_done=0; out_data and out_last read 0.
  - FIFO storage need not be cleared; contents are discarded.
- After reset deasserts, tready=1 from the first clock edge.
- tready = (level != DEPTH). It is driven from registered state only; there is no combinational path from tvalid, tdata or tlast.
- Push: tvalid && tready at a rising edge writes {tlast, tdata} at wr_ptr, then wr_ptr+1 (wraps modulo DEPTH).
- A pushed beat appears on out_valid/out_data/out_last in the cycle after the accepting edge (1-cycle latency, FWFT).
- Pop: rd && out_valid at an edge advances rd_ptr (wraps modulo DEPTH). rd while out_valid=0 is ignored; no underflow.
- Level update:
  - Push only: level+1.
  - Pop only: level-1.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
- Full (level=DEPTH): tready=0, so no push is possible. A pop on that edge makes tready=1 in the next cycle (one bubble; no same-cycle pass-through).
- Empty with a simultaneous push and rd: the pop is ignored; the beat is retained and visible next cycle.
- The master may hold tvalid with changing tdata while tready=0. Nothing is captured until the accepting edge.
- Counters:
  - beat_count: +1 on each accepted non-tlast beat; reset to 0 on an accepted tlast beat.
  - pkt_count: +1 on each accepted tlast beat; wraps from 2^CNT_WIDTH-1 to 0.
  - beat_count saturates at all-ones and does not wrap.
- pkt_done is a registered pulse, high for exactly the one cycle following the accepting edge of a tlast beat. Back-to-back tlast beats keep it high for consecutive cycles.
- Single-beat packets (tlast on the first beat) are legal: pkt_count+1, beat_count stays 0.
- Reset mid-packet or mid-transfer aborts immediately. The partial packet is not counted and buffered beats are lost. tready stays 0 until reset deasserts.

Decomposition:
- Shared package axis_pkg holds:
  - AXIS_DATA_WIDTH (32) and AXIS_CNT_WIDTH (16) defaults.
  - Typedef axis_beat_t = {last, data} as the FIFO entry format; axis_m uses the same type.
- Natural sub-module: axis_s_fifo, a synchronous FWFT FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
- axis_s itself holds the handshake, pop qualification and counters.

Test Plan:
- Single beat:
  - Stimulus: after reset, master sends 32'haaaa_bbbb with tlast=1 while rd=0.
  - Response: out_valid=1 and out_data=32'haaaa_bbbb one cycle after acceptance; out_last=1, level=1, pkt_done pulses once, pkt_count=1.
- Back-to-back:
  - Stimulus: beats 32'hcccc_dddd (tlast=0) then 32'h1234_5678 (tlast=1) on consecutive cycles; then pop twice.
  - Response: data pops in order, beat_count 1 then 0, pkt_count increments by 1, level returns to 0.
- Full/backpressure:
  - Stimulus: push DEPTH=4 beats 1,2,3,4 with rd=0, holding tvalid with beat 5.
  - Response: tready=0 at level 4 and beat 5 is not captured. One pop gives tready=1 next cycle, beat 5 is accepted, and the pop order is 1..5.
- Simultaneous push/pop:
  - Stimulus: at level=2, assert tvalid and rd together for 3 cycles.
  - Response: level stays 2 throughout and data order is preserved.
- Empty pop:
  - Stimulus: rd=1 with FIFO empty for 3 cycles, then a push.
  - Response: pointers are unchanged and the pushed beat appears correctly with level=1.
- Reset mid-packet:
  - Stimulus: 2 non-last beats accepted, then areset_n pulsed high asynchronously (not clock-aligned).
  - Response: tready, out_valid, level, beat_count and pkt_count are 0 immediately. After release, a fresh 1-beat packet gives pkt_count=1.
